// File: rtl/laser_scan_if.sv
// Point-load / result bus for laser_scan.
// master drives points, slave (the scanner) returns centres and cover.
interface laser_scan_if #(
    parameter int N_PTS = 40,
    parameter int CW    = 4
);
    localparam int NW = $clog2(N_PTS + 1);

    logic          IN_VALID;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic [CW-1:0] C1X;
    logic [CW-1:0] C1Y;
    logic [CW-1:0] C2X;
    logic [CW-1:0] C2Y;
    logic [NW-1:0] COVER;
    logic          BUSY;
    logic          DONE;

    modport master (
        output IN_VALID, X, Y,
        input  C1X, C1Y, C2X, C2Y, COVER, BUSY, DONE
    );

    modport slave (
        input  IN_VALID, X, Y,
        output C1X, C1Y, C2X, C2Y, COVER, BUSY, DONE
    );
endinterface

// File: rtl/laser_scan.sv
// Two-circle coverage search by alternating raster scans over the grid.
// Optional LASER_REFINE_EN repeats A/B rounds while union cover improves.
module laser_scan #(
    parameter int N_PTS    = 40,
    parameter int CW       = 4,
    parameter int R2       = 16,
    parameter int MAX_ITER = 4
) (
    input logic         CLK,
    input logic         RST_N,
    laser_scan_if.slave bus
);
    localparam int AW = 2 * CW;
    localparam int SN = 1 << AW;
    localparam int DW = 2 * CW + 3;
    localparam int NW = $clog2(N_PTS + 1);
    localparam int KW = (N_PTS > 1) ? $clog2(N_PTS) : 1;
    localparam logic signed [DW-1:0] R2S = DW'(R2);

    typedef enum logic [2:0] {
        LOAD,
        SCAN_A,
        SCAN_B,
        CHECK,
        FINISH
    } state_t;

    function automatic logic hit(
        input logic [CW-1:0] cx,
        input logic [CW-1:0] cy,
        input logic [CW-1:0] px,
        input logic [CW-1:0] py
    );
        logic signed [DW-1:0] dx;
        logic signed [DW-1:0] dy;
        dx = $signed({{(DW-CW){1'b0}}, cx})
           - $signed({{(DW-CW){1'b0}}, px});
        dy = $signed({{(DW-CW){1'b0}}, cy})
           - $signed({{(DW-CW){1'b0}}, py});
        return (dx * dx + dy * dy) <= R2S;
    endfunction

    state_t        state;
    logic [KW-1:0] k;
    logic [AW:0]   idx;
    logic [CW-1:0] px [N_PTS];
    logic [CW-1:0] py [N_PTS];
    logic [CW-1:0] c1x, c1y, c2x, c2y;
    logic          c2_ok;
    logic [NW-1:0] cnt_q;
    logic [AW-1:0] cnt_pos;
    logic          cnt_vld;
    logic [NW-1:0] best_cnt;
    logic [AW-1:0] best_pos;

`ifdef LASER_REFINE_EN
    localparam int RW = $clog2(MAX_ITER + 1);
    logic [NW-1:0] prev;
    logic [RW-1:0] rounds;
`endif

    logic [N_PTS-1:0] cov_c1;
    logic [N_PTS-1:0] cov_c2;
    logic [N_PTS-1:0] cov_cd;
    logic [N_PTS-1:0] excl;
    logic [NW-1:0]    cnt_n;
    logic [NW-1:0]    uni_n;
    logic             upd;
    logic [AW-1:0]    nb_pos;
    logic [NW-1:0]    nb_cnt;

    // Candidate index is the raster position: low half x, high half y.
    always_comb begin
        cnt_n = '0;
        uni_n = '0;
        for (int i = 0; i < N_PTS; i++) begin
            cov_c1[i] = hit(c1x, c1y, px[i], py[i]);
            cov_c2[i] = c2_ok && hit(c2x, c2y, px[i], py[i]);
            cov_cd[i] = hit(idx[CW-1:0], idx[AW-1:CW], px[i], py[i]);
            excl[i]   = (state == SCAN_A) ? cov_c2[i] : cov_c1[i];
            if (cov_cd[i] && !excl[i])
                cnt_n = cnt_n + NW'(1);
            if (cov_c1[i] || cov_c2[i])
                uni_n = uni_n + NW'(1);
        end
    end

    // Strictly greater only, so the earliest raster position keeps ties.
    always_comb begin
        upd    = cnt_vld && (cnt_q > best_cnt);
        nb_pos = upd ? cnt_pos : best_pos;
        nb_cnt = upd ? cnt_q : best_cnt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= LOAD;
            k         <= '0;
            idx       <= '0;
            for (int i = 0; i < N_PTS; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
            c1x       <= '0;
            c1y       <= '0;
            c2x       <= '0;
            c2y       <= '0;
            c2_ok     <= 1'b0;
            cnt_q     <= '0;
            cnt_pos   <= '0;
            cnt_vld   <= 1'b0;
            best_cnt  <= '0;
            best_pos  <= '0;
`ifdef LASER_REFINE_EN
            prev      <= '0;
            rounds    <= '0;
`endif
            bus.C1X   <= '0;
            bus.C1Y   <= '0;
            bus.C2X   <= '0;
            bus.C2Y   <= '0;
            bus.COVER <= '0;
            bus.BUSY  <= 1'b0;
            bus.DONE  <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (bus.IN_VALID) begin
                        px[k] <= bus.X;
                        py[k] <= bus.Y;
                        if (k == KW'(N_PTS - 1)) begin
                            k        <= '0;
                            state    <= SCAN_A;
                            bus.BUSY <= 1'b1;
                            idx      <= '0;
                            cnt_vld  <= 1'b0;
                            best_cnt <= '0;
                            best_pos <= '0;
                            c2_ok    <= 1'b0;
`ifdef LASER_REFINE_EN
                            prev     <= '0;
                            rounds   <= '0;
`endif
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                SCAN_A, SCAN_B: begin
                    if (idx != (AW+1)'(SN)) begin
                        cnt_q    <= cnt_n;
                        cnt_pos  <= idx[AW-1:0];
                        cnt_vld  <= 1'b1;
                        idx      <= idx + (AW+1)'(1);
                        best_cnt <= nb_cnt;
                        best_pos <= nb_pos;
                    end else begin
                        idx      <= '0;
                        cnt_vld  <= 1'b0;
                        best_cnt <= '0;
                        best_pos <= '0;
                        if (state == SCAN_A) begin
                            c1x   <= nb_pos[CW-1:0];
                            c1y   <= nb_pos[AW-1:CW];
                            state <= SCAN_B;
                        end else begin
                            c2x   <= nb_pos[CW-1:0];
                            c2y   <= nb_pos[AW-1:CW];
                            c2_ok <= 1'b1;
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
`ifdef LASER_REFINE_EN
                    if (uni_n > prev &&
                        (rounds + RW'(1)) < RW'(MAX_ITER)) begin
                        prev   <= uni_n;
                        rounds <= rounds + RW'(1);
                        state  <= SCAN_A;
                    end else begin
                        state  <= FINISH;
                    end
`else
                    state <= FINISH;
`endif
                end
                FINISH: begin
                    bus.DONE  <= 1'b1;
                    bus.C1X   <= c1x;
                    bus.C1Y   <= c1y;
                    bus.C2X   <= c2x;
                    bus.C2Y   <= c2y;
                    bus.COVER <= uni_n;
                    bus.BUSY  <= 1'b0;
                    k         <= '0;
                    state     <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: doc/laser_scan.md
LASER_SCAN -- requirements
Module: laser_scan

Interface
REQ-001 SHALL have parameters: N_PTS, 40, points per pattern; CW, 4, coordinate width (grid 2^CW x 2^CW); R2, 16, squared coverage radius; MAX_ITER, 4, max refinement rounds.
REQ-002 SHALL have ports:
- CLK  in  1  clock; one clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  point-valid qualifier.
- X, Y  in  CW each  point coordinates.
- C1X, C1Y, C2X, C2Y  out  CW each  circle centres.
- COVER  out  clog2(N_PTS+1)  points covered by C1 or C2.
- BUSY  out  1  high in any state except LOAD.
- DONE  out  1  one-cycle result strobe.

Function
REQ-003 SHALL implement states LOAD, SCAN_A, SCAN_B, CHECK and FINISH.
REQ-004 In LOAD, SHALL store (X,Y) into point slot k (k = 0..N_PTS-1) on each edge with IN_VALID=1; IN_VALID=0 cycles insert no point; after slot N_PTS-1 is written, next state SHALL be SCAN_A.
REQ-005 SHALL ignore IN_VALID outside LOAD.
REQ-006 Point i is covered by centre (cx,cy) iff (cx-px)^2+(cy-py)^2 <= R2, computed without overflow (signed CW+1 differences, 2CW+3-bit sum).
REQ-007 Each scan SHALL visit candidates in raster order: y outer, x inner, 0..2^CW-1, one candidate per cycle, evaluating all N_PTS points in parallel; count registered one cycle later; scan length 2^(2*CW)+1 cycles.
REQ-008 SCAN_A SHALL select C1 maximising points not covered by current C2; SCAN_B SHALL select C2 maximising points not covered by current C1.
REQ-009 Scan best SHALL initialise to count 0 at candidate (0,0); replace only on strictly greater count (first-in-raster wins ties).
REQ-010 Before the first SCAN_A of a pattern, C2 SHALL be treated as covering no points.
REQ-011 CHECK SHALL compute union coverage of C1,C2; if it strictly exceeds the previous round's value and rounds < MAX_ITER, go to SCAN_A; otherwise go to FINISH.
REQ-012 FINISH SHALL drive DONE=1 for exactly one cycle with C1*, C2*, COVER valid, then return to LOAD with the point count cleared.
REQ-013 C1*/C2*/COVER SHALL hold their values from FINISH until the next FINISH or reset.
REQ-014 A new pattern SHALL be accepted in the cycle after DONE without reset.

Reset
REQ-015 RST_N=0 SHALL immediately clear state to LOAD, point count, round count, and all outputs to 0 (DONE=0, BUSY=0), including mid-scan.
REQ-016 After RST_N deasserts, the first valid point SHALL be accepted on the first rising edge with IN_VALID=1.

Configuration
REQ-017 Macro LASER_REFINE_EN: when defined, CHECK behaves per REQ-011; when undefined, CHECK always goes to FINISH (single SCAN_A+SCAN_B pass) and MAX_ITER is unused.
REQ-018 With LASER_REFINE_EN undefined, DONE SHALL rise 2*(2^(2*CW)+1)+2 edges after the edge accepting the last point (516 for CW=4).

Verification
REQ-019 All 40 points at (5,5), defaults -> C1=(5,1), C2=(0,0), COVER=40, one DONE pulse.
REQ-020 20 points at (0,0) and 20 at (15,15) -> C1=(0,0), C2=(15,11), COVER=40.
REQ-021 Same data as REQ-020 with IN_VALID low for 3 cycles after point 10 -> identical outputs; DONE 3 cycles later.
REQ-022 RST_N pulsed low during SCAN_B -> all outputs 0, BUSY=0 asynchronously; reloading the REQ-020 pattern gives REQ-020 results.
REQ-023 REQ-019 pattern immediately followed by REQ-020 pattern with no reset -> two DONE pulses with the respective results.
REQ-024 Macro undefined, REQ-020 pattern -> DONE exactly 516 cycles after the last accept; macro defined -> COVER >= macro-undefined COVER on the same patterns.
